conv_par_engine: RTL and testbench

CONV_PAR_ENGINE -- requirements
Module: conv_par_engine

---
 rtl/conv_pkg.sv | 32 +++
 rtl/conv_mac_lane.sv | 66 ++++++
 rtl/conv_par_engine.sv | 239 +++++++++++++++++++++++
 tb/tb_conv_par_engine.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// ============================================================================
// conv_pkg : shared FSM state encoding and saturation helper for conv engine
// Revision : 1.0
// ============================================================================
`default_nettype none

package conv_pkg;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_HANDOFF = 2'd3
    } conv_state_e;

    // Clamp a signed value to the range of a w-bit two's complement number.
    function automatic logic signed [63:0] sat_to(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/conv_mac_lane.sv
// ============================================================================
// conv_mac_lane : registered saturating multiply feeding a saturating adder
// Revision      : 1.0
// ============================================================================
`default_nettype none

module conv_mac_lane
    import conv_pkg::*;
#(
    parameter int T = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [T-1:0] x,
    input  logic [T-1:0] f,
    output logic [T-1:0] acc
);

    logic [T-1:0] prod_q, prod_d;
    logic         pv_q, pv_d;
    logic [T-1:0] acc_q, acc_d;

    logic signed [2*T-1:0] prod_full;
    logic signed [T:0]     sum;
    logic [T-1:0]          prod_sat;
    logic [T-1:0]          sum_sat;

    assign prod_full = $signed(x) * $signed(f);
    assign prod_sat  = T'(sat_to(64'(prod_full), T));
    assign sum       = $signed({acc_q[T-1], acc_q}) + $signed({prod_q[T-1], prod_q});
    assign sum_sat   = T'(sat_to(64'(sum), T));

    // The adder consumes the product registered in the previous cycle.
    always_comb begin
        prod_d = prod_q;
        pv_d   = en && !clr;
        acc_d  = acc_q;
        if (en) begin
            prod_d = prod_sat;
        end
        if (clr) begin
            acc_d = '0;
        end else if (pv_q) begin
            acc_d = sum_sat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prod_q <= '0;
            pv_q   <= 1'b0;
            acc_q  <= '0;
        end else begin
            prod_q <= prod_d;
            pv_q   <= pv_d;
            acc_q  <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

`default_nettype wire

// File: rtl/conv_par_engine.sv
// ============================================================================
// conv_par_engine : P-lane parallel 1-D convolution, valid/ready streaming
// Revision        : 1.0
// ============================================================================
`default_nettype none

module conv_par_engine
    import conv_pkg::*;
#(
    parameter int T    = 8,
    parameter int N    = 128,
    parameter int M    = 32,
    parameter int P    = 4,
    parameter int RELU = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [T-1:0] s_data_in_x,
    input  logic         s_valid_x,
    output logic         s_ready_x,
    input  logic [T-1:0] s_data_in_f,
    input  logic         s_valid_f,
    output logic         s_ready_f,
    output logic [T-1:0] m_data_out_y,
    output logic         m_valid_y,
    input  logic         m_ready_y
);

    localparam int L    = N - M + 1;
    localparam int G    = (L + P - 1) / P;
    localparam int LAST = L - (G - 1) * P;
    localparam int XCW  = $clog2(N + 1);
    localparam int FCW  = $clog2(M + 1);
    localparam int XW   = (N > 1) ? $clog2(N) : 1;
    localparam int FW   = (M > 1) ? $clog2(M) : 1;
    localparam int GW   = (G > 1) ? $clog2(G) : 1;
    localparam int IW   = $clog2(N + P + M + 1);
    localparam int PW   = (P > 1) ? $clog2(P) : 1;
    localparam int CW   = $clog2(P + 1);

    conv_state_e    state_q, state_d;
    logic [XCW-1:0] x_cnt_q, x_cnt_d;
    logic [FCW-1:0] f_cnt_q, f_cnt_d;
    logic           rdy_x_q, rdy_x_d;
    logic           rdy_f_q, rdy_f_d;
    logic [FW-1:0]  j_q, j_d;
    logic [GW-1:0]  g_q, g_d;
    logic [IW-1:0]  base_q, base_d;
    logic           copied_q, copied_d;
    logic [T-1:0]   buf_q [P];
    logic [T-1:0]   buf_d [P];
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           valid_q, valid_d;
    logic [T-1:0]   data_q, data_d;

    logic           clr, load_buf, x_xfer, f_xfer, pop, g_last, lane_en;
    logic [T-1:0]   x_mem_q [N];
    logic [T-1:0]   f_mem_q [M];
    logic [T-1:0]   f_cur;
    logic [T-1:0]   lane_x   [P];
    logic [T-1:0]   lane_acc [P];
    logic [T-1:0]   lane_y   [P];

    assign x_xfer  = s_valid_x && rdy_x_q;
    assign f_xfer  = s_valid_f && rdy_f_q;
    assign pop     = valid_q && m_ready_y;
    assign g_last  = (g_q == GW'(G - 1));
    assign lane_en = (state_q == ST_COMPUTE);
    assign f_cur   = f_mem_q[j_q];

    always_ff @(posedge clk) begin
        if (x_xfer) begin
            x_mem_q[x_cnt_q[XW-1:0]] <= s_data_in_x;
        end
        if (f_xfer) begin
            f_mem_q[f_cnt_q[FW-1:0]] <= s_data_in_f;
        end
    end

    for (genvar p = 0; p < P; p++) begin : g_lane
        logic [IW-1:0] idx;
        assign idx = base_q + IW'(p) + IW'(j_q);
        // Lanes of a partial final group may point past x; they are never emitted.
        assign lane_x[p] = (idx < IW'(N)) ? x_mem_q[idx[XW-1:0]] : '0;

        conv_mac_lane #(.T(T)) u_lane (
            .clk   (clk),
            .reset (reset),
            .clr   (clr),
            .en    (lane_en),
            .x     (lane_x[p]),
            .f     (f_cur),
            .acc   (lane_acc[p])
        );

        assign lane_y[p] = ((RELU != 0) && lane_acc[p][T-1]) ? '0 : lane_acc[p];
    end

    always_comb begin
        state_d  = state_q;
        x_cnt_d  = x_cnt_q;
        f_cnt_d  = f_cnt_q;
        rdy_x_d  = rdy_x_q;
        rdy_f_d  = rdy_f_q;
        j_d      = j_q;
        g_d      = g_q;
        base_d   = base_q;
        copied_d = copied_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        clr      = 1'b0;
        load_buf = 1'b0;

        if (x_xfer) begin
            x_cnt_d = x_cnt_q + 1'b1;
            if (x_cnt_q == XCW'(N - 1)) begin
                rdy_x_d = 1'b0;
            end
        end
        if (f_xfer) begin
            f_cnt_d = f_cnt_q + 1'b1;
            if (f_cnt_q == FCW'(M - 1)) begin
                rdy_f_d = 1'b0;
            end
        end

        case (state_q)
            ST_LOAD: begin
                if (!rdy_x_q && !rdy_f_q) begin
                    state_d = ST_COMPUTE;
                    clr     = 1'b1;
                    j_d     = '0;
                    g_d     = '0;
                    base_d  = '0;
                end
            end
            ST_COMPUTE: begin
                if (j_q == FW'(M - 1)) begin
                    state_d = ST_DRAIN;
                    j_d     = '0;
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                state_d  = ST_HANDOFF;
                copied_d = 1'b0;
            end
            ST_HANDOFF: begin
                // The final group stays here after its copy until the buffer is drained.
                if (!copied_q) begin
                    if (cnt_q == '0) begin
                        load_buf = 1'b1;
                        if (!g_last) begin
                            state_d = ST_COMPUTE;
                            clr     = 1'b1;
                            g_d     = g_q + 1'b1;
                            base_d  = base_q + IW'(P);
                        end else begin
                            copied_d = 1'b1;
                        end
                    end
                end else if (pop && (cnt_q == CW'(1))) begin
                    state_d  = ST_LOAD;
                    rdy_x_d  = 1'b1;
                    rdy_f_d  = 1'b1;
                    x_cnt_d  = '0;
                    f_cnt_d  = '0;
                    copied_d = 1'b0;
                end
            end
            default: state_d = ST_LOAD;
        endcase

        for (int i = 0; i < P; i++) begin
            buf_d[i] = load_buf ? lane_y[i] : buf_q[i];
        end
        if (load_buf) begin
            cnt_d    = g_last ? CW'(LAST) : CW'(P);
            rd_ptr_d = '0;
            data_d   = lane_y[0];
        end else if (pop) begin
            cnt_d    = cnt_q - 1'b1;
            rd_ptr_d = rd_ptr_q + 1'b1;
            if (cnt_q > CW'(1)) begin
                data_d = buf_q[rd_ptr_q + 1'b1];
            end
        end
        valid_d = (cnt_d != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_LOAD;
            x_cnt_q  <= '0;
            f_cnt_q  <= '0;
            rdy_x_q  <= 1'b1;
            rdy_f_q  <= 1'b1;
            j_q      <= '0;
            g_q      <= '0;
            base_q   <= '0;
            copied_q <= 1'b0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            for (int i = 0; i < P; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            x_cnt_q  <= x_cnt_d;
            f_cnt_q  <= f_cnt_d;
            rdy_x_q  <= rdy_x_d;
            rdy_f_q  <= rdy_f_d;
            j_q      <= j_d;
            g_q      <= g_d;
            base_q   <= base_d;
            copied_q <= copied_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            for (int i = 0; i < P; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

    assign s_ready_x    = rdy_x_q;
    assign s_ready_f    = rdy_f_q;
    assign m_valid_y    = valid_q;
    assign m_data_out_y = data_q;

endmodule

`default_nettype wire

// File: tb/tb_conv_par_engine.sv
// ============================================================================
// tb_conv_par_engine : directed self-checking bench, three engine configurations
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_conv_par_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [7:0] xd [3];
    logic [7:0] fd [3];
    logic       vx [3];
    logic       vf [3];
    logic       ry [3];
    logic       rx [3];
    logic       rf [3];
    logic       vy [3];
    logic [7:0] y  [3];

    int cyc    = 0;
    int passes = 0;
    int fails  = 0;
    int total  = 0;
    int xv   [8];
    int fv   [4];
    int expv [6];

    always @(posedge clk) cyc <= cyc + 1;

    // 0: M=3 RELU=0   1: M=4 RELU=0   2: M=3 RELU=1
    conv_par_engine #(.T(8), .N(8), .M(3), .P(2), .RELU(0)) dut_a (
        .clk(clk), .reset(reset),
        .s_data_in_x(xd[0]), .s_valid_x(vx[0]), .s_ready_x(rx[0]),
        .s_data_in_f(fd[0]), .s_valid_f(vf[0]), .s_ready_f(rf[0]),
        .m_data_out_y(y[0]), .m_valid_y(vy[0]), .m_ready_y(ry[0]));

    conv_par_engine #(.T(8), .N(8), .M(4), .P(2), .RELU(0)) dut_b (
        .clk(clk), .reset(reset),
        .s_data_in_x(xd[1]), .s_valid_x(vx[1]), .s_ready_x(rx[1]),
        .s_data_in_f(fd[1]), .s_valid_f(vf[1]), .s_ready_f(rf[1]),
        .m_data_out_y(y[1]), .m_valid_y(vy[1]), .m_ready_y(ry[1]));

    conv_par_engine #(.T(8), .N(8), .M(3), .P(2), .RELU(1)) dut_c (
        .clk(clk), .reset(reset),
        .s_data_in_x(xd[2]), .s_valid_x(vx[2]), .s_ready_x(rx[2]),
        .s_data_in_f(fd[2]), .s_valid_f(vf[2]), .s_ready_f(rf[2]),
        .m_data_out_y(y[2]), .m_valid_y(vy[2]), .m_ready_y(ry[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d required %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic load_job(input int d, input int m);
        int xi;
        int fi;
        xi = 0;
        fi = 0;
        for (int c = 0; c < 64 && (xi < 8 || fi < m); c++) begin
            @(negedge clk);
            if (xi < 8 && rx[d]) begin
                vx[d] = 1'b1; xd[d] = 8'(xv[xi]); xi++;
            end else begin
                vx[d] = 1'b0;
            end
            if (fi < m && rf[d]) begin
                vf[d] = 1'b1; fd[d] = 8'(fv[fi]); fi++;
            end else begin
                vf[d] = 1'b0;
            end
        end
        check("load_count", 32'(xi + fi), 32'(8 + m));
    endtask

    task automatic collect(input int d, input int m, input int nexp, input bit stall, input string tag);
        int  got;
        int  t_full;
        int  t_first;
        int  stall_left;
        int  extras;
        bit  held;
        logic r;
        got = 0; t_full = -1; t_first = -1; stall_left = 0; extras = 0; held = 1'b0;
        for (int c = 0; c < 300 && got < nexp; c++) begin
            @(negedge clk);
            vx[d] = 1'b0;
            vf[d] = 1'b0;
            // The job enters COMPUTE in the first cycle both loaders show not-ready.
            if (t_full < 0 && !rx[d] && !rf[d]) t_full = cyc;
            if (t_first < 0 && vy[d]) t_first = cyc;
            r = 1'b1;
            if (stall_left > 0) begin
                r = 1'b0;
                stall_left--;
                if (vy[d]) begin
                    held = 1'b1;
                    check({tag, "_hold_data"}, 32'($signed(y[d])), 32'(expv[2]));
                end else if (held) begin
                    check({tag, "_hold_valid"}, 32'(vy[d]), 32'd1);
                end
            end
            ry[d] = r;
            if (vy[d] && r) begin
                check({tag, "_y"}, 32'($signed(y[d])), 32'(expv[got]));
                got++;
                if (stall && got == 2) stall_left = 10;
            end
        end
        check({tag, "_count"}, 32'(got), 32'(nexp));
        check({tag, "_latency"}, 32'(t_first - t_full), 32'(m + 3));
        @(negedge clk);
        check({tag, "_rdy_x_back"}, 32'(rx[d]), 32'd1);
        check({tag, "_rdy_f_back"}, 32'(rf[d]), 32'd1);
        for (int c = 0; c < 8; c++) begin
            if (vy[d]) extras++;
            @(negedge clk);
        end
        check({tag, "_no_extra_y"}, 32'(extras), 32'd0);
    endtask

    task automatic ramp_x();
        for (int i = 0; i < 8; i++) xv[i] = i + 1;
    endtask

    task automatic ramp_exp(input int start, input int step);
        for (int i = 0; i < 6; i++) expv[i] = start + i * step;
    endtask

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 3; d++) begin
            xd[d] = '0; fd[d] = '0; vx[d] = 1'b0; vf[d] = 1'b0; ry[d] = 1'b1;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("reset_rdy_x", 32'(rx[d]), 32'd1);
            check("reset_rdy_f", 32'(rf[d]), 32'd1);
            check("reset_valid", 32'(vy[d]), 32'd0);
            check("reset_data", 32'(y[d]), 32'd0);
        end
        reset = 1'b0;

        // Sum of three consecutive samples.
        ramp_x(); fv[0] = 1; fv[1] = 1; fv[2] = 1;
        ramp_exp(6, 3);
        load_job(0, 3);
        collect(0, 3, 6, 1'b0, "basic");

        // Partial last group: picks x[k] directly.
        fv[0] = 1; fv[1] = 0; fv[2] = 0; fv[3] = 0;
        ramp_exp(1, 1);
        load_job(1, 4);
        collect(1, 4, 5, 1'b0, "partial");

        for (int i = 0; i < 8; i++) xv[i] = 127;
        fv[0] = 127; fv[1] = 127; fv[2] = 127;
        ramp_exp(127, 0);
        load_job(0, 3);
        collect(0, 3, 6, 1'b0, "sat_pos");

        for (int i = 0; i < 8; i++) xv[i] = -128;
        ramp_exp(-128, 0);
        load_job(0, 3);
        collect(0, 3, 6, 1'b0, "sat_neg");

        ramp_x(); fv[0] = -1; fv[1] = -1; fv[2] = -1;
        ramp_exp(0, 0);
        load_job(2, 3);
        collect(2, 3, 6, 1'b0, "relu_on");

        ramp_exp(-6, -3);
        load_job(0, 3);
        collect(0, 3, 6, 1'b0, "relu_off");

        fv[0] = 1; fv[1] = 1; fv[2] = 1;
        ramp_exp(6, 3);
        load_job(0, 3);
        collect(0, 3, 6, 1'b1, "backpressure");

        // Abort a job two cycles into COMPUTE.
        load_job(0, 3);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            vx[0] = 1'b0; vf[0] = 1'b0;
            if (!rx[0] && !rf[0]) break;
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_rdy_x", 32'(rx[0]), 32'd1);
        check("midreset_rdy_f", 32'(rf[0]), 32'd1);
        check("midreset_valid", 32'(vy[0]), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        load_job(0, 3);
        collect(0, 3, 6, 1'b0, "after_reset");

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

`default_nettype wire
